spi_reg_frame: RTL and testbench
================================

Name: spi_reg_frame

Overview:
- Frame parser and register bank directly downstream of the SPI slave byte engine. Consumes its done/dout/frame_start/frame_end and drives its din.
- Decodes a command byte, then streams data bytes into or out of an 8-bit register bank with address auto-increment.
- The bank's flat output feeds the motor/servo drivers of the sculpture.

Parameters:
- NUM_REGS, 16, number of 8-bit registers (2..128).
- ADDR_W, 4, width of internal address, must equal clog2(NUM_REGS).
- STATUS_BYTE, 8'hA5, value presented on din while no register read is active.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- frame_start  in  1  one-cycle pulse, ss asserted
- frame_end  in  1  one-cycle pulse, ss released
- done  in  1  one-cycle pulse, byte received
- dout  in  8  received byte, valid with done
- din  out  8  next byte to shift out to master
- regs  out  NUM_REGS*8  flat register bank, reg i at [8*i+7:8*i]
- wr_en  out  1  one-cycle pulse per register write
- wr_addr  out  ADDR_W  address written, valid with wr_en
- wr_data  out  8  data written, valid with wr_en
- busy  out  1  high while state is not IDLE

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, all regs=0, wr_en=0, wr_addr=0, wr_data=0, din=STATUS_BYTE, busy=0.
  - Reset mid-frame abandons the frame. Bytes are ignored until the next frame_start.
- Command byte: bit7 = rw (1 = read, 0 = write), bits6:0 = address.
- States:
  - IDLE: frame_start -> CMD. done is ignored.
  - CMD: done -> if dout[6:0] >= NUM_REGS then SINK, else DATA; latch rw and addr = dout[ADDR_W-1:0].
  - DATA, write (rw=0): on done, regs[addr] <= dout; wr_en=1, wr_addr=addr, wr_data=dout in the same registered cycle (one cycle after done); addr increments.
  - DATA, read (rw=1): on done, addr increments.
  - SINK: all done pulses ignored. No writes. din=8'hFF.
  - Any state: frame_end -> IDLE. frame_start while not IDLE -> CMD (restart; addr/rw cleared).
- din (registered, updates one cycle after the causing event; it must be stable before the next byte's first SCK edge):
  - IDLE/CMD: STATUS_BYTE.
  - DATA read: regs[addr] for the current addr. After the command done it shows regs[cmd_addr]; after each data done it shows regs[addr+1].
  - DATA write: regs[addr] (pre-write value of the next target).
  - SINK: 8'hFF.
- Address increment wraps NUM_REGS-1 -> 0 (modulo NUM_REGS, not 2^ADDR_W).
- Simultaneous done and frame_end: the byte is applied first (write and wr_en happen), then the state goes to IDLE.
- Simultaneous done and frame_start: the byte is dropped and the state goes to CMD.
- Frame ending right after CMD (no data bytes): no write, no side effects.
- regs output is updated in the same cycle as wr_en.

Optional Feature:
- SPI_REG_AUTOINC_EN
  - Defined: addr increments after every data byte, with the wrap rule above.
  - Undefined: addr is held at the command address for the whole frame. Repeated writes overwrite one register; repeated reads return the same register (streaming mode). All other behaviour is unchanged.

Decomposition:
- Package spi_reg_pkg holds:
  - CMD_RW_BIT = 7, CMD_ADDR_MSB = 6.
  - SINK_BYTE = 8'hFF.
  - State enum {IDLE, CMD, DATA, SINK}.
- One sub-module, spi_reg_bank:
  - NUM_REGS x 8 storage with synchronous active-low clear.
  - Single write port (we, waddr, wdata) and combinational read mux (raddr -> rdata) plus flat regs bus.
- The FSM, address counter and din register stay in spi_reg_frame.

Test Plan:
- Write burst: frame_start, bytes 0x02, 0x11, 0x22, frame_end -> regs[2]=0x11, regs[3]=0x22; two wr_en pulses with wr_addr 2, 3; busy low after frame_end.
- Read burst: preload regs[5]=0x5A, regs[6]=0x6B; send 0x85, then two dummy bytes -> din=0x5A one cycle after the command done, then din=0x6B one cycle after the next done; regs unchanged.
- Wrap: NUM_REGS=16, write 0x0F, 0xAA, 0xBB -> regs[15]=0xAA, regs[0]=0xBB.
- Invalid address: command 0x20 with NUM_REGS=16, then 0x33 -> state SINK, din=0xFF, no wr_en, regs unchanged.
- Edge cases:
  - done coincident with frame_end on write data 0x44 to addr 1 -> regs[1]=0x44, state IDLE.
  - frame_start mid-frame -> next byte decoded as a command.
- Reset mid-write frame (rst=0 for one cycle after the command byte), then data byte 0x77 -> regs all 0, no wr_en, din=0xA5.
- Build without SPI_REG_AUTOINC_EN: write 0x03, 0x01, 0x02 -> regs[3]=0x02, regs[4] unchanged.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI register frame parser.
package spi_reg_pkg;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

  localparam logic [7:0] SINK_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    SINK = 2'd3
  } state_t;

endpackage

// File: rtl/spi_reg_frame_if.sv
// Byte-level link between the SPI slave byte engine (master side) and the frame parser (slave side).
interface spi_reg_frame_if;

  logic       frame_start;
  logic       frame_end;
  logic       done;
  logic [7:0] dout;
  logic [7:0] din;

  modport master (
    output frame_start,
    output frame_end,
    output done,
    output dout,
    input  din
  );

  modport slave (
    input  frame_start,
    input  frame_end,
    input  done,
    input  dout,
    output din
  );

endinterface

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8 register storage: one write port, combinational read mux, flat output bus.
module spi_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] regs
);

  logic [7:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/spi_reg_frame.sv
// SPI command/data frame parser driving an 8-bit register bank.
// Define SPI_REG_AUTOINC_EN to advance the address after every data byte; otherwise it streams one register.
//
//   state | meaning
//   IDLE  | no frame open, bytes ignored
//   CMD   | waiting for the command byte (rw + address)
//   DATA  | streaming data bytes to/from the bank
//   SINK  | address out of range, bytes ignored, din = 0xFF
module spi_reg_frame
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_frame_if.slave        bus,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              rw, rw_d;
  logic [7:0]        din_q, din_d;
  logic              wr_stb;
  logic [7:0]        rdata;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    rw_d    = rw;
    wr_stb  = 1'b0;
    if (bus.frame_start) begin
      // restart wins over any byte completing in the same cycle
      state_d = CMD;
      addr_d  = '0;
      rw_d    = 1'b0;
    end else begin
      unique case (state)
        CMD: if (bus.done) begin
          rw_d    = bus.dout[CMD_RW_BIT];
          addr_d  = bus.dout[ADDR_W-1:0];
          state_d = ({1'b0, bus.dout[CMD_ADDR_MSB:0]} >= NUM_REGS_B) ? SINK : DATA;
        end
        DATA: if (bus.done) begin
          wr_stb = !rw;
`ifdef SPI_REG_AUTOINC_EN
          addr_d = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
`endif
        end
        default: ;
      endcase
      // a byte coinciding with frame_end is still applied above
      if (bus.frame_end) state_d = IDLE;
    end

    unique case (state_d)
      DATA:    din_d = rdata;
      SINK:    din_d = SINK_BYTE;
      default: din_d = STATUS_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr    <= '0;
      rw      <= 1'b0;
      din_q   <= STATUS_BYTE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      addr  <= addr_d;
      rw    <= rw_d;
      din_q <= din_d;
      wr_en <= wr_stb;
      if (wr_stb) begin
        wr_addr <= addr;
        wr_data <= bus.dout;
      end
    end
  end

  // bank writes on the same edge that raises wr_en; reads follow the next address
  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_stb),
    .waddr (addr),
    .wdata (bus.dout),
    .raddr (addr_d),
    .rdata (rdata),
    .regs  (regs)
  );

  assign bus.din = din_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_frame.sv
// Directed self-checking bench for spi_reg_frame; expectations follow SPI_REG_AUTOINC_EN when defined.
module tb_spi_reg_frame;
  import spi_reg_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REGS*8-1:0] regs;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;
  logic                  busy;

  spi_reg_frame_if bus ();

  spi_reg_frame #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .STATUS_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .regs    (regs),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m [NUM_REGS];

  function automatic logic [7:0] rg(int i);
    return regs[8*i +: 8];
  endfunction

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = m[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic fe, input logic dn, input logic [7:0] b);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.done        = dn;
    bus.dout        = b;
    tick();
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.done        = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, a);
    drive(0, 0, 1, d);
    drive(0, 1, 0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.din !== 8'hA5) begin n_err++; $display("FAIL rst_din got %h exp a5", bus.din); end
    n_cmp++; if ({busy, wr_en} !== 2'b00) begin n_err++; $display("FAIL rst_busy_wren got %b exp 00", {busy, wr_en}); end
    n_cmp++; if ({wr_addr, wr_data} !== 12'h000) begin n_err++; $display("FAIL rst_wr_bus got %h exp 000", {wr_addr, wr_data}); end
    n_cmp++; if (regs !== '0) begin n_err++; $display("FAIL rst_regs got %h exp 0", regs); end
    rst = 1'b1;
    tick();
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h55);
    n_cmp++; if ({busy, wr_en} !== 2'b00) begin n_err++; $display("FAIL idle_ignore got %b exp 00", {busy, wr_en}); end
    n_cmp++; if (regs !== '0) begin n_err++; $display("FAIL idle_regs got %h exp 0", regs); end
  endtask

  task automatic test_write_burst();
    logic [ADDR_W-1:0] exp_a;
    drive(1, 0, 0, 8'h00);
    n_cmp++; if ({busy, bus.din} !== 9'h1A5) begin n_err++; $display("FAIL wb_cmd_state got %h exp 1a5", {busy, bus.din}); end
    drive(0, 0, 1, 8'h02);
    n_cmp++; if ({wr_en, bus.din} !== 9'h000) begin n_err++; $display("FAIL wb_after_cmd got %h exp 000", {wr_en, bus.din}); end
    drive(0, 0, 1, 8'h11);
    m[2] = 8'h11;
    n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd2, 8'h11}) begin n_err++; $display("FAIL wb_wr1 got %h exp 1211", {wr_en, wr_addr, wr_data}); end
    n_cmp++; if (rg(2) !== 8'h11) begin n_err++; $display("FAIL wb_reg2 got %h exp 11", rg(2)); end
    drive(0, 0, 1, 8'h22);
`ifdef SPI_REG_AUTOINC_EN
    exp_a = 4'd3;
`else
    exp_a = 4'd2;
`endif
    m[exp_a] = 8'h22;
    n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, exp_a, 8'h22}) begin n_err++; $display("FAIL wb_wr2 got %h exp %h", {wr_en, wr_addr, wr_data}, {1'b1, exp_a, 8'h22}); end
    drive(0, 1, 0, 8'h00);
    n_cmp++; if ({busy, wr_en, bus.din} !== 10'h0A5) begin n_err++; $display("FAIL wb_end got %h exp 0a5", {busy, wr_en, bus.din}); end
    n_cmp++; if (regs !== model_flat()) begin n_err++; $display("FAIL wb_regs got %h exp %h", regs, model_flat()); end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_d1, exp_d2;
    write_reg(8'h05, 8'h5A);
    write_reg(8'h06, 8'h6B);
    m[5] = 8'h5A;
    m[6] = 8'h6B;
`ifdef SPI_REG_AUTOINC_EN
    exp_d1 = 8'h6B;
    exp_d2 = m[7];
`else
    exp_d1 = 8'h5A;
    exp_d2 = 8'h5A;
`endif
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h85);
    n_cmp++; if (bus.din !== 8'h5A) begin n_err++; $display("FAIL rd_first got %h exp 5a", bus.din); end
    drive(0, 0, 1, 8'h00);
    n_cmp++; if ({wr_en, bus.din} !== {1'b0, exp_d1}) begin n_err++; $display("FAIL rd_second got %h exp %h", {wr_en, bus.din}, {1'b0, exp_d1}); end
    drive(0, 0, 1, 8'h00);
    n_cmp++; if ({wr_en, bus.din} !== {1'b0, exp_d2}) begin n_err++; $display("FAIL rd_third got %h exp %h", {wr_en, bus.din}, {1'b0, exp_d2}); end
    drive(0, 1, 0, 8'h00);
    n_cmp++; if (regs !== model_flat()) begin n_err++; $display("FAIL rd_regs got %h exp %h", regs, model_flat()); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a;
`ifdef SPI_REG_AUTOINC_EN
    exp_a = 4'd0;
`else
    exp_a = 4'd15;
`endif
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h0F);
    drive(0, 0, 1, 8'hAA);
    m[15] = 8'hAA;
    n_cmp++; if ({wr_en, wr_addr} !== 5'h1F) begin n_err++; $display("FAIL wrap_wr1 got %h exp 1f", {wr_en, wr_addr}); end
    drive(0, 0, 1, 8'hBB);
    m[exp_a] = 8'hBB;
    n_cmp++; if ({wr_en, wr_addr} !== {1'b1, exp_a}) begin n_err++; $display("FAIL wrap_wr2 got %h exp %h", {wr_en, wr_addr}, {1'b1, exp_a}); end
    drive(0, 1, 0, 8'h00);
    n_cmp++; if ({rg(15), rg(0)} !== {m[15], m[0]}) begin n_err++; $display("FAIL wrap_regs got %h exp %h", {rg(15), rg(0)}, {m[15], m[0]}); end
  endtask

  task automatic test_invalid();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h20);
    n_cmp++; if ({busy, bus.din} !== 9'h1FF) begin n_err++; $display("FAIL inv_sink got %h exp 1ff", {busy, bus.din}); end
    drive(0, 0, 1, 8'h33);
    n_cmp++; if ({wr_en, bus.din} !== 9'h0FF) begin n_err++; $display("FAIL inv_byte got %h exp 0ff", {wr_en, bus.din}); end
    drive(0, 1, 0, 8'h00);
    n_cmp++; if ({busy, bus.din} !== 9'h0A5) begin n_err++; $display("FAIL inv_end got %h exp 0a5", {busy, bus.din}); end
    n_cmp++; if (regs !== model_flat()) begin n_err++; $display("FAIL inv_regs got %h exp %h", regs, model_flat()); end
  endtask

  task automatic test_end_with_done();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h01);
    drive(0, 1, 1, 8'h44);
    m[1] = 8'h44;
    n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd1, 8'h44}) begin n_err++; $display("FAIL ewd_wr got %h exp 1144", {wr_en, wr_addr, wr_data}); end
    n_cmp++; if ({busy, rg(1)} !== 9'h044) begin n_err++; $display("FAIL ewd_state got %h exp 044", {busy, rg(1)}); end
  endtask

  task automatic test_restart();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h02);
    drive(1, 0, 1, 8'h99);
    n_cmp++; if ({busy, wr_en, bus.din} !== 10'h2A5) begin n_err++; $display("FAIL rs_drop got %h exp 2a5", {busy, wr_en, bus.din}); end
    drive(0, 0, 1, 8'h04);
    n_cmp++; if ({wr_en, bus.din} !== {1'b0, m[4]}) begin n_err++; $display("FAIL rs_cmd got %h exp %h", {wr_en, bus.din}, {1'b0, m[4]}); end
    drive(0, 0, 1, 8'h5C);
    m[4] = 8'h5C;
    n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd4, 8'h5C}) begin n_err++; $display("FAIL rs_wr got %h exp 145c", {wr_en, wr_addr, wr_data}); end
    drive(0, 1, 0, 8'h00);
    n_cmp++; if (regs !== model_flat()) begin n_err++; $display("FAIL rs_regs got %h exp %h", regs, model_flat()); end
  endtask

  task automatic test_stream();
    write_reg(8'h03, 8'h00);
    m[3] = 8'h00;
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h03);
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h02);
    drive(0, 1, 0, 8'h00);
`ifdef SPI_REG_AUTOINC_EN
    m[3] = 8'h01;
    m[4] = 8'h02;
`else
    m[3] = 8'h02;
`endif
    n_cmp++; if ({rg(3), rg(4)} !== {m[3], m[4]}) begin n_err++; $display("FAIL st_regs got %h exp %h", {rg(3), rg(4)}, {m[3], m[4]}); end
    n_cmp++; if (regs !== model_flat()) begin n_err++; $display("FAIL st_bank got %h exp %h", regs, model_flat()); end
  endtask

  task automatic test_reset_mid_frame();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h01);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(0, 0, 1, 8'h77);
    n_cmp++; if ({busy, wr_en, bus.din} !== 10'h0A5) begin n_err++; $display("FAIL rmf_state got %h exp 0a5", {busy, wr_en, bus.din}); end
    n_cmp++; if (regs !== '0) begin n_err++; $display("FAIL rmf_regs got %h exp 0", regs); end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.done        = 1'b0;
    bus.dout        = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) m[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_invalid();
    test_end_with_done();
    test_restart();
    test_stream();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
